// File: rtl/pkt_router_n.sv
// Parametrised 1-to-NUM_PORTS packet router. Header-steered per-port FIFOs with
// whole-packet space reservation, bad-header drop and per-port timeout flush.
module pkt_router_n #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TIMEOUT    = 30
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            pkt_valid,
   input  logic [DATA_WIDTH-1:0]           data_in,
   output logic                            busy,
   input  logic [NUM_PORTS-1:0]            read_enb,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
   output logic [NUM_PORTS-1:0]            vld_out,
   output logic [NUM_PORTS-1:0]            soft_reset,
   output logic                            err,
   output logic                            drop
);
   localparam int unsigned ADDR_W = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned LEN_W  = DATA_WIDTH - ADDR_W;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W  = PTR_W + 1;
   localparam int unsigned CMP_W  = ((LEN_W > OCC_W) ? LEN_W : OCC_W) + 2;
   localparam int unsigned TC_W   = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, WAIT_SPACE, LOAD, CHECK, DROP} state_t;
   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0]           hdr_q, parity_acc_q;
   logic [LEN_W-1:0]                cnt_q;
   logic                            len_bad_q;
   logic                            busy_q, busy_d, err_q, err_d, drop_q, drop_d;

   logic [DATA_WIDTH-1:0]           mem_q [NUM_PORTS][FIFO_DEPTH];
   logic [PTR_W-1:0]                wr_ptr_q [NUM_PORTS];
   logic [PTR_W-1:0]                rd_ptr_q [NUM_PORTS];
   logic [OCC_W-1:0]                occ_q [NUM_PORTS];
   logic [TC_W-1:0]                 tcnt_q [NUM_PORTS];
   logic [NUM_PORTS*DATA_WIDTH-1:0] data_out_q;
   logic [NUM_PORTS-1:0]            soft_reset_q;

   logic [ADDR_W-1:0]               in_dest, dest_q, sel_dest;
   logic [LEN_W-1:0]                in_len, len_q, sel_len;
   logic [OCC_W-1:0]                occ_sel;
   logic                            dest_ok, fits, bad_hdr, wr_en;
   logic [DATA_WIDTH-1:0]           wr_data;
   logic [NUM_PORTS-1:0]            we, re, flush;

   assign in_dest  = data_in[ADDR_W-1:0];
   assign in_len   = data_in[DATA_WIDTH-1:ADDR_W];
   assign dest_q   = hdr_q[ADDR_W-1:0];
   assign len_q    = hdr_q[DATA_WIDTH-1:ADDR_W];
   assign sel_dest = (state_q == IDLE) ? in_dest : dest_q;
   assign sel_len  = (state_q == IDLE) ? in_len  : len_q;

   // Occupancy of the addressed port and validity of an incoming destination
   always_comb begin
      occ_sel = '0;
      dest_ok = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (sel_dest == ADDR_W'(i)) occ_sel = occ_q[i];
         if (in_dest == ADDR_W'(i))  dest_ok = 1'b1;
      end
   end

   // Space check ignores same-cycle reads; the whole packet must fit up front
   assign fits    = (CMP_W'(FIFO_DEPTH) - CMP_W'(occ_sel)) >= (CMP_W'(sel_len) + CMP_W'(2));
   assign bad_hdr = !dest_ok || ((CMP_W'(in_len) + CMP_W'(2)) > CMP_W'(FIFO_DEPTH));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (pkt_valid) state_d = bad_hdr ? DROP : (fits ? LOAD : WAIT_SPACE);
         WAIT_SPACE: if (fits) state_d = LOAD;
         LOAD:       if (!pkt_valid) state_d = CHECK;
         CHECK:      state_d = IDLE;
         DROP:       if (!pkt_valid) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d  = (state_d == WAIT_SPACE) || (state_d == CHECK);
      err_d   = 1'b0;
      drop_d  = 1'b0;
      wr_en   = 1'b0;
      wr_data = data_in;
      unique case (state_q)
         IDLE: begin
            drop_d = pkt_valid && bad_hdr;
            wr_en  = pkt_valid && !bad_hdr && fits;
         end
         WAIT_SPACE: begin
            wr_en   = fits;
            wr_data = hdr_q;
         end
         LOAD: begin
            wr_en = !pkt_valid || (cnt_q < len_q);
            err_d = !pkt_valid && ((parity_acc_q != data_in) || (cnt_q != len_q) || len_bad_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hdr_q        <= '0;
         parity_acc_q <= '0;
         cnt_q        <= '0;
         len_bad_q    <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
         drop_q <= drop_d;
         if (state_q == IDLE && pkt_valid) begin
            hdr_q        <= data_in;
            parity_acc_q <= data_in;
            cnt_q        <= '0;
            len_bad_q    <= 1'b0;
         end else if (state_q == LOAD && pkt_valid) begin
            if (cnt_q < len_q) begin
               parity_acc_q <= parity_acc_q ^ data_in;
               cnt_q        <= cnt_q + LEN_W'(1);
            end else begin
               len_bad_q <= 1'b1;
            end
         end
      end
   end

   // Flush is held off while the port is mid-packet; tcnt waits saturated
   always_comb begin
      we    = '0;
      re    = '0;
      flush = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         we[i]    = wr_en && (sel_dest == ADDR_W'(i));
         flush[i] = (tcnt_q[i] == TC_W'(TIMEOUT)) &&
                    !(((state_q == LOAD) || (state_q == CHECK)) && (dest_q == ADDR_W'(i)));
         re[i]    = read_enb[i] && (occ_q[i] != '0) && !flush[i];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            occ_q[i]    <= '0;
            tcnt_q[i]   <= '0;
         end
         data_out_q   <= '0;
         soft_reset_q <= '0;
      end else begin
         soft_reset_q <= flush;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (we[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
            if (flush[i]) begin
               rd_ptr_q[i] <= wr_ptr_q[i];
               occ_q[i]    <= OCC_W'(we[i]);
               tcnt_q[i]   <= '0;
            end else begin
               if (re[i]) begin
                  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                  data_out_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_q[i][rd_ptr_q[i]];
               end
               occ_q[i] <= occ_q[i] + OCC_W'(we[i]) - OCC_W'(re[i]);
               if ((occ_q[i] == '0) || read_enb[i])  tcnt_q[i] <= '0;
               else if (tcnt_q[i] != TC_W'(TIMEOUT)) tcnt_q[i] <= tcnt_q[i] + TC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_PORTS; i++)
         if (we[i]) mem_q[i][wr_ptr_q[i]] <= wr_data;
   end

   always_comb begin
      vld_out = '0;
      for (int i = 0; i < NUM_PORTS; i++) vld_out[i] = (occ_q[i] != '0);
   end

   assign busy       = busy_q;
   assign err        = err_q;
   assign drop       = drop_q;
   assign data_out   = data_out_q;
   assign soft_reset = soft_reset_q;
endmodule

// File: tb/tb_pkt_router_n.sv
// Directed bench for pkt_router_n at default parameters (4 ports, 8-bit, depth 16, timeout 30).
`timescale 1ns/1ps
module tb_pkt_router_n;
   localparam int unsigned NP = 4;
   localparam int unsigned DW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          pkt_valid;
   logic [DW-1:0] data_in;
   logic          busy;
   logic [NP-1:0] read_enb;
   logic [NP*DW-1:0] data_out;
   logic [NP-1:0] vld_out;
   logic [NP-1:0] soft_reset;
   logic          err;
   logic          drop;

   int tests_run    = 0;
   int tests_failed = 0;

   pkt_router_n dut (
      .clock      (clock),
      .reset      (reset),
      .pkt_valid  (pkt_valid),
      .data_in    (data_in),
      .busy       (busy),
      .read_enb   (read_enb),
      .data_out   (data_out),
      .vld_out    (vld_out),
      .soft_reset (soft_reset),
      .err        (err),
      .drop       (drop)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] dout(input int p);
      return data_out[p*DW +: DW];
   endfunction

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; pkt_valid = 1'b0; data_in = '0; read_enb = '0;
      repeat (2) @(posedge clock);
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests_run++; if (vld_out !== 4'h0) begin tests_failed++; $display("FAIL reset_vld: got %b want 0000", vld_out); end
      tests_run++; if (data_out !== 32'h0) begin tests_failed++; $display("FAIL reset_dout: got %h want 0", data_out); end
      tests_run++; if ({soft_reset, err, drop} !== 6'b0) begin tests_failed++; $display("FAIL reset_pulses: got %b want 0", {soft_reset, err, drop}); end
      reset = 1'b0;
      tick();
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      logic [7:0] beats [5];
      int vld_cnt;
      beats = '{8'h0E, 8'h11, 8'h22, 8'h33, 8'h0E};
      vld_cnt = 0;
      read_enb = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         pkt_valid = (k < 4); data_in = beats[k];
         tick();
         if (vld_out[2]) vld_cnt++;
         if (k >= 1) begin
            tests_run++; if (dout(2) !== beats[k-1]) begin tests_failed++; $display("FAIL basic_dout%0d: got %h want %h", k-1, dout(2), beats[k-1]); end
         end
         tests_run++; if (busy !== (k == 4)) begin tests_failed++; $display("FAIL basic_busy%0d: got %b want %b", k, busy, (k == 4)); end
         tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_err%0d: got %b want 0", k, err); end
      end
      pkt_valid = 1'b0;
      tick();
      if (vld_out[2]) vld_cnt++;
      tests_run++; if (dout(2) !== 8'h0E) begin tests_failed++; $display("FAIL basic_parity_out: got %h want 0e", dout(2)); end
      tests_run++; if (vld_cnt != 5) begin tests_failed++; $display("FAIL basic_vld_cycles: got %0d want 5", vld_cnt); end
      tick();
      tests_run++; if (dout(2) !== 8'h0E || vld_out[2] !== 1'b0) begin tests_failed++; $display("FAIL basic_empty_read: got %h/%b want 0e/0", dout(2), vld_out[2]); end
      read_enb = '0;
   endtask

   task automatic test_bad_parity();
      logic [7:0] beats [5];
      int err_early;
      beats = '{8'h0E, 8'h11, 8'h22, 8'h33, 8'h0F};
      err_early = 0;
      read_enb = '0;
      for (int k = 0; k < 5; k++) begin
         pkt_valid = (k < 4); data_in = beats[k];
         tick();
         if (k < 4 && err) err_early++;
      end
      tests_run++; if (err !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL badpar_check: got err=%b busy=%b want 1/1", err, busy); end
      tests_run++; if (err_early != 0) begin tests_failed++; $display("FAIL badpar_early_err: got %0d want 0", err_early); end
      pkt_valid = 1'b0;
      tick();
      tests_run++; if (err !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL badpar_pulse_end: got err=%b busy=%b want 0/0", err, busy); end
      read_enb = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         tick();
         tests_run++; if (dout(2) !== beats[k]) begin tests_failed++; $display("FAIL badpar_dout%0d: got %h want %h", k, dout(2), beats[k]); end
      end
      read_enb = '0;
      tests_run++; if (vld_out[2] !== 1'b0) begin tests_failed++; $display("FAIL badpar_drained: got %b want 0", vld_out[2]); end
   endtask

   task automatic test_wait_space();
      logic [7:0] exp_seq [16];
      for (int b = 1; b <= 10; b++) exp_seq[b-1] = 8'(b);
      exp_seq[10] = 8'h22; exp_seq[11] = 8'h0D; exp_seq[12] = 8'h31;
      exp_seq[13] = 8'h32; exp_seq[14] = 8'h33; exp_seq[15] = 8'h3D;
      read_enb = '0;
      pkt_valid = 1'b1; data_in = 8'h29;
      tick();
      for (int b = 1; b <= 10; b++) begin data_in = 8'(b); tick(); end
      pkt_valid = 1'b0; data_in = 8'h22;
      tick();
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL ws_fill_err: got %b want 0", err); end
      tick();
      pkt_valid = 1'b1; data_in = 8'h0D;
      tick();
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ws_busy_enter: got %b want 1", busy); end
      tick();
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ws_busy_hold: got %b want 1", busy); end
      read_enb = 4'b0010;
      tick();
      read_enb = '0;
      tests_run++; if (busy !== 1'b1 || dout(1) !== 8'h29) begin tests_failed++; $display("FAIL ws_read_uncredited: got busy=%b dout=%h want 1/29", busy, dout(1)); end
      tick();
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ws_busy_release: got %b want 0", busy); end
      data_in = 8'h31; tick();
      data_in = 8'h32; tick();
      data_in = 8'h33; tick();
      pkt_valid = 1'b0; data_in = 8'h3D;
      tick();
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL ws_pkt_err: got %b want 0", err); end
      tick();
      read_enb = 4'b0010;
      for (int k = 0; k < 16; k++) begin
         tick();
         tests_run++; if (dout(1) !== exp_seq[k]) begin tests_failed++; $display("FAIL ws_dout%0d: got %h want %h", k, dout(1), exp_seq[k]); end
      end
      read_enb = '0;
      tests_run++; if (vld_out[1] !== 1'b0) begin tests_failed++; $display("FAIL ws_drained: got %b want 0", vld_out[1]); end
   endtask

   task automatic test_drop();
      logic [7:0] exp_seq [3];
      exp_seq = '{8'h04, 8'hA5, 8'hA1};
      read_enb = '0;
      pkt_valid = 1'b1; data_in = 8'h51;
      tick();
      tests_run++; if (drop !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL drop_pulse: got drop=%b busy=%b want 1/0", drop, busy); end
      data_in = 8'hAA;
      tick();
      tests_run++; if (drop !== 1'b0) begin tests_failed++; $display("FAIL drop_one_cycle: got %b want 0", drop); end
      data_in = 8'hBB; tick();
      pkt_valid = 1'b0; data_in = 8'hCC; tick();
      tests_run++; if (vld_out !== 4'b0000) begin tests_failed++; $display("FAIL drop_no_write: got %b want 0000", vld_out); end
      pkt_valid = 1'b1; data_in = 8'h04;
      tick();
      tests_run++; if (vld_out !== 4'b0001 || busy !== 1'b0) begin tests_failed++; $display("FAIL drop_next_hdr: got vld=%b busy=%b want 0001/0", vld_out, busy); end
      data_in = 8'hA5; tick();
      pkt_valid = 1'b0; data_in = 8'hA1; tick();
      tests_run++; if (err !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL drop_next_check: got err=%b busy=%b want 0/1", err, busy); end
      tick();
      read_enb = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests_run++; if (dout(0) !== exp_seq[k]) begin tests_failed++; $display("FAIL drop_next_dout%0d: got %h want %h", k, dout(0), exp_seq[k]); end
      end
      read_enb = '0;
   endtask

   task automatic test_timeout();
      int first_sr, sr_cnt, other_sr;
      logic v30, v31;
      first_sr = -1; sr_cnt = 0; other_sr = 0; v30 = 1'b0; v31 = 1'b1;
      read_enb = '0;
      pkt_valid = 1'b1; data_in = 8'h03;
      tick();
      pkt_valid = 1'b0; data_in = 8'h03;
      tick();
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL to_len0_err: got %b want 0", err); end
      tick();
      for (int k = 3; k <= 40; k++) begin
         tick();
         if (soft_reset[3]) begin sr_cnt++; if (first_sr < 0) first_sr = k; end
         if (soft_reset[2:0] != 3'b000) other_sr++;
         if (k == 30) v30 = vld_out[3];
         if (k == 31) v31 = vld_out[3];
      end
      tests_run++; if (first_sr != 31) begin tests_failed++; $display("FAIL to_pulse_cycle: got %0d want 31", first_sr); end
      tests_run++; if (sr_cnt != 1) begin tests_failed++; $display("FAIL to_pulse_width: got %0d want 1", sr_cnt); end
      tests_run++; if (v30 !== 1'b1 || v31 !== 1'b0) begin tests_failed++; $display("FAIL to_vld: got %b%b want 10", v30, v31); end
      tests_run++; if (other_sr != 0) begin tests_failed++; $display("FAIL to_other_ports: got %0d want 0", other_sr); end
   endtask

   task automatic test_reset_mid();
      read_enb = '0;
      pkt_valid = 1'b1; data_in = 8'h0E; tick();
      data_in = 8'h11; tick();
      data_in = 8'h22; tick();
      tests_run++; if (vld_out[2] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre: got %b want 1", vld_out[2]); end
      #2 reset = 1'b1;
      #1;
      tests_run++; if (vld_out !== 4'b0000 || busy !== 1'b0 || data_out !== 32'h0) begin tests_failed++; $display("FAIL rstmid_async: got vld=%b busy=%b dout=%h want 0/0/0", vld_out, busy, data_out); end
      #1 reset = 1'b0;
      pkt_valid = 1'b1; data_in = 8'h04;
      tick();
      tests_run++; if (vld_out !== 4'b0001 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_hdr: got vld=%b busy=%b want 0001/0", vld_out, busy); end
      data_in = 8'hA5; tick();
      pkt_valid = 1'b0; data_in = 8'hA1; tick();
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_err: got %b want 0", err); end
      tick();
      read_enb = 4'b0001;
      tick();
      read_enb = '0;
      tests_run++; if (dout(0) !== 8'h04) begin tests_failed++; $display("FAIL rstmid_dout: got %h want 04", dout(0)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_parity();
      test_wait_space();
      test_drop();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t reached, want earlier finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
